// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID probe master and its stall timer.
package sysid_probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    FIN   = 2'd3
  } probe_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sysid_probe_stall_timer.sv
// Saturating waitrequest stall counter; expired is high once the count equals limit.
module sysid_probe_stall_timer
  import sysid_probe_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [STALL_CNT_W-1:0] limit,
  output logic                   expired
);

  logic [STALL_CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM read master that fetches and checks the system-ID and timestamp words.
// Optional stall timeout built only when SYSID_PROBE_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start or the one-shot auto-start after reset
// RD_ID | reading address 0 (ID word)
// RD_TS | reading address 1 (timestamp word)
// FIN   | one-cycle done pulse, ok flags valid
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1476470101,
  parameter bit          AUTO_START     = 1'b1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_word,
  output logic [31:0] ts_word,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("sysid_probe_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  probe_state_t state;
  logic         auto_pending;
  logic         stall_expired;

`ifdef SYSID_PROBE_TIMEOUT_EN
  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES);

  // Any cycle that is not a stalled read clears the count, so it starts at 0 in each read state.
  logic stall_clear;
  logic stall_enable;

  assign stall_enable = avm_read && avm_waitrequest;
  assign stall_clear  = !stall_enable;

  sysid_probe_stall_timer u_stall_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (stall_clear),
    .enable  (stall_enable),
    .limit   (STALL_LIMIT),
    .expired (stall_expired)
  );
`else
  assign stall_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      auto_pending <= AUTO_START;
      avm_address  <= SYSID_ADDR_ID;
      avm_read     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      id_word      <= '0;
      ts_word      <= '0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || auto_pending) begin
            state        <= RD_ID;
            auto_pending <= 1'b0;
            avm_read     <= 1'b1;
            avm_address  <= SYSID_ADDR_ID;
            busy         <= 1'b1;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            timeout      <= 1'b0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_word     <= avm_readdata;
            state       <= RD_TS;
            avm_address <= SYSID_ADDR_TS;
          end else if (stall_expired) begin
            state       <= FIN;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            done        <= 1'b1;
            timeout     <= 1'b1;
          end
        end
        RD_TS: begin
          state       <= FIN;
          avm_read    <= 1'b0;
          avm_address <= SYSID_ADDR_ID;
          done        <= 1'b1;
          // Flags are compared at the capture edge so they appear together with done.
          if (!avm_waitrequest) begin
            ts_word <= avm_readdata;
            ts_ok   <= (avm_readdata == EXPECTED_TS);
            id_ok   <= (id_word == EXPECTED_ID);
          end else if (stall_expired) begin
            timeout <= 1'b1;
          end else begin
            state       <= RD_TS;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
            done        <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_probe_master.sv
// Directed self-checking bench for sysid_probe_master with a small behavioural Avalon slave.
module tb_sysid_probe_master;

  localparam logic [31:0] EXP_TS = 32'd1476470101;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic [31:0] id_word;
  logic [31:0] ts_word;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;

  logic [31:0] id_val = 32'd0;
  logic [31:0] ts_val = EXP_TS;
  int          id_stall = 0;
  int          ts_stall = 0;
  bit          stuck = 1'b0;
  int          stall_cnt = 0;
  int          need;
  bit          was_stalled = 1'b0;
  logic        prev_addr = 1'b0;
  int          addr_glitch = 0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sysid_probe_master #(
    .EXPECTED_ID    (32'd0),
    .EXPECTED_TS    (EXP_TS),
    .AUTO_START     (1'b1),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_word         (id_word),
    .ts_word         (ts_word),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout)
  );

  // Slave: stalls id_stall/ts_stall cycles per read, or forever when stuck.
  always_comb begin
    avm_readdata    = avm_address ? ts_val : id_val;
    need            = avm_address ? ts_stall : id_stall;
    avm_waitrequest = avm_read && (stuck || (stall_cnt < need));
  end

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (was_stalled && avm_read && (avm_address != prev_addr)) addr_glitch <= addr_glitch + 1;
    was_stalled <= avm_read && avm_waitrequest;
    prev_addr   <= avm_address;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_start(output int lat);
    start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int first;
    int second;
    int pulses;
    int seen;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_id_ok", id_ok, 0);
    check("rst_ts_ok", ts_ok, 0);
    check("rst_timeout", timeout, 0);
    check("rst_id_word", id_word, 0);
    check("rst_ts_word", ts_word, 0);

    // Auto-start with matching slave
    reset_n = 1'b1;
    wait_done(lat);
    check("auto_latency", lat, 3);
    check("auto_id_ok", id_ok, 1);
    check("auto_ts_ok", ts_ok, 1);
    check("auto_ts_word", ts_word, EXP_TS);
    check("auto_id_word", id_word, 0);
    check("auto_timeout", timeout, 0);
    check("auto_busy_fin", busy, 1);
    @(negedge clock);
    check("auto_done_pulse", done, 0);
    check("auto_busy_idle", busy, 0);
    check("auto_ok_held", id_ok, 1);
    repeat (3) @(negedge clock);
    check("auto_once", busy, 0);

    // ID mismatch
    id_val = 32'h1;
    run_start(lat);
    check("mis_latency", lat, 3);
    check("mis_id_ok", id_ok, 0);
    check("mis_ts_ok", ts_ok, 1);
    check("mis_id_word", id_word, 32'h1);
    id_val = 32'h0;
    repeat (2) @(negedge clock);

    // Stalls: 3 on ID read, 2 on TS read
    id_stall = 3;
    ts_stall = 2;
    run_start(lat);
    check("stall_latency", lat, 8);
    check("stall_id_ok", id_ok, 1);
    check("stall_ts_ok", ts_ok, 1);
    check("stall_read_low", avm_read, 0);
    id_stall = 0;
    ts_stall = 0;
    repeat (2) @(negedge clock);

    // start held across a whole sequence
    first = -1;
    second = -1;
    pulses = 0;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (done) begin
        pulses++;
        if (first < 0) first = k;
        else second = k;
      end
      if (k == 4) check("held_idle_gap", busy, 0);
    end
    start = 1'b0;
    check("held_first", first, 3);
    check("held_second", second, 7);
    check("held_pulses", pulses, 2);
    repeat (3) @(negedge clock);
    check("held_quiet", busy, 0);

    // Stuck waitrequest
    id_val = 32'hDEAD_BEEF;
    stuck = 1'b1;
`ifdef SYSID_PROBE_TIMEOUT_EN
    run_start(lat);
    check("to_latency", lat, 6);
    check("to_timeout", timeout, 1);
    check("to_id_ok", id_ok, 0);
    check("to_ts_ok", ts_ok, 0);
    check("to_id_word_kept", id_word, 0);
    check("to_read_low", avm_read, 0);
    stuck = 1'b0;
    @(negedge clock);
    check("to_busy_idle", busy, 0);
    check("to_timeout_held", timeout, 1);
`else
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("nto_no_done", seen, 0);
    check("nto_busy", busy, 1);
    check("nto_read", avm_read, 1);
    check("nto_timeout", timeout, 0);
    stuck = 1'b0;
    repeat (5) @(negedge clock);
`endif
    repeat (2) @(negedge clock);

    // Reset during RD_TS
    id_val = 32'h0000_1234;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("mid_in_rd_ts", avm_address, 1);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_read", avm_read, 0);
    check("mid_rst_addr", avm_address, 0);
    check("mid_rst_id_word", id_word, 0);
    check("mid_rst_ts_word", ts_word, 0);
    check("mid_rst_id_ok", id_ok, 0);
    check("mid_rst_ts_ok", ts_ok, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_done", done, 0);
    id_val = 32'h0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_done(lat);
    check("mid_restart_latency", lat, 3);
    check("mid_restart_id_ok", id_ok, 1);
    check("mid_restart_ts_ok", ts_ok, 1);
    repeat (2) @(negedge clock);

    check("addr_stable_in_stall", addr_glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
